// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the Nexys2 seven-segment scan controller.
//   state_t   - scan FSM states (BLANK: all anodes off, DRIVE: one digit lit)
//   SEG_TABLE - hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern
//   SEG_OFF   - all cathodes off
//   AN_OFF    - all anodes off
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Entry 15 is the leftmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running prescaler producing a one-clock enable pulse
// every TICK_DIV clocks (no derived clock).
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   o_tick  - high for one clock while the count sits at TICK_DIV-1
module scan_tick_gen #(
  parameter int TICK_DIV = 5000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: round-robin scan controller for a 4-digit common-anode
// seven-segment display, with a blanking gap before every digit and
// frame-synchronous update of the displayed value.
//   clk_50MHz   - system clock
//   rst_n       - asynchronous active-low reset
//   value_in    - four hex nibbles, [3:0] is digit 0 (rightmost)
//   dp_in       - decimal point request per digit, 1 = lit
//   load        - one-cycle strobe capturing value_in/dp_in into the pending buffer
//   digit_en    - live per-digit enable, 0 keeps that digit dark
//   an          - anode drive, active-low
//   seg         - cathodes {g,f,e,d,c,b,a}, active-low
//   dp          - decimal point cathode, active-low
//   frame_start - one-clock pulse when digit 0 enters DRIVE
module seg7_scan_ctrl #(
  parameter int TICK_DIV    = 5000,
  parameter int DRIVE_TICKS = 19,
  parameter int BLANK_TICKS = 1
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  import seg7_pkg::*;

  localparam int PH_MAX = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  logic            w_tick;
  state_t          r_state, w_state_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic            w_frame_entry;

  logic [15:0]     r_act_val, r_pend_val;
  logic [3:0]      r_act_dp, r_pend_dp;
  logic            r_pend_vld;

  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_frame_start;
  logic [3:0]      w_nib;

  scan_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk  (clk_50MHz),
    .i_rst_n(rst_n),
    .o_tick (w_tick)
  );

  // ---- scan FSM: state register ----
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_idx   <= 2'd0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // ---- scan FSM: next state, only moves on a prescaler tick ----
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_phase_nxt   = r_phase;
    w_frame_entry = 1'b0;
    if (w_tick) begin
      case (r_state)
        BLANK: begin
          if (r_phase == PH_W'(BLANK_TICKS - 1)) begin
            w_state_nxt   = DRIVE;
            w_phase_nxt   = '0;
            w_frame_entry = (r_idx == 2'd0);
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
        DRIVE: begin
          if (r_phase == PH_W'(DRIVE_TICKS - 1)) begin
            w_state_nxt = BLANK;
            w_idx_nxt   = r_idx + 2'd1;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
        default: begin
          w_state_nxt = BLANK;
        end
      endcase
    end
  end

  // ---- shadow registers: pending buffer and frame-synchronous active copy ----
  // On the frame boundary the active copy takes whatever was pending before
  // this clock; a load landing on the same clock re-arms pending for the next frame.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (w_frame_entry && r_pend_vld) begin
        r_act_val  <= r_pend_val;
        r_act_dp   <= r_pend_dp;
        r_pend_vld <= 1'b0;
      end
      if (load) begin
        r_pend_val <= value_in;
        r_pend_dp  <= dp_in;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign w_nib = r_act_val[{r_idx, 2'b00} +: 4];

  // ---- registered outputs, one clock behind state/idx/active ----
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_entry;
      if (r_state == DRIVE) begin
        r_an  <= digit_en[r_idx] ? ~(4'b0001 << r_idx) : AN_OFF;
        r_seg <= hex_to_seg(w_nib);
        r_dp  <= ~r_act_dp[r_idx];
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic        clk_50MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic [15:0] value_in  = '0;
  logic [3:0]  dp_in     = '0;
  logic        load      = 1'b0;
  logic [3:0]  digit_en  = 4'hF;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int e        = 0;   // rising edges since the last reset release

  seg7_scan_ctrl #(
    .TICK_DIV   (4),
    .DRIVE_TICKS(3),
    .BLANK_TICKS(1)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_50MHz);
    #1;
    e++;
  endtask

  task automatic goto_edge(input int t);
    while (e < t) adv();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    adv();
    load     = 1'b0;
  endtask

  task automatic digit(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    check({tag, "_an"},  32'(an),  32'(exp_an));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  // At most one anode may ever be low.
  always @(negedge clk_50MHz) begin
    if (rst_n) check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  initial begin
    // Reset held: outputs idle.
    repeat (3) @(posedge clk_50MHz);
    #2;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);

    @(negedge clk_50MHz);
    rst_n = 1'b1;
    e = 0;

    // First frame_start 4 clocks after release; digit 0 shows 0.
    goto_edge(3);  check("fs_pre", 32'(frame_start), 32'd0);
    goto_edge(4);  check("fs_first", 32'(frame_start), 32'd1);
    goto_edge(5);  check("fs_width", 32'(frame_start), 32'd0);
    digit("f1d0", 4'hE, 7'h40);
    check("f1d0_dp", 32'(dp), 32'd1);

    // Load 1234, pending until the next frame.
    do_load(16'h1234, 4'b0001);
    goto_edge(58); digit("f1d3_old", 4'h7, 7'h40);

    // Frame 2 starts at edge 68.
    goto_edge(74);  digit("f2d0", 4'hE, 7'h19); check("f2d0_dp", 32'(dp), 32'd0);
    goto_edge(80);  check("blank_pre", 32'(an), 32'hE);
    goto_edge(81);  check("blank_first", 32'(an), 32'hF);
    goto_edge(84);  check("blank_last", 32'(an), 32'hF);
    goto_edge(85);  check("blank_post", 32'(an), 32'hD);
    goto_edge(90);  digit("f2d1", 4'hD, 7'h30); check("f2d1_dp", 32'(dp), 32'd1);
    goto_edge(106); digit("f2d2", 4'hB, 7'h24);
    goto_edge(122); digit("f2d3", 4'h7, 7'h79);
    goto_edge(131); check("fs_period_pre", 32'(frame_start), 32'd0);
    goto_edge(132); check("fs_period", 32'(frame_start), 32'd1);

    // Frame 3: only digits 1 and 3 enabled.
    digit_en = 4'b1010;
    goto_edge(133); check("fs_period_post", 32'(frame_start), 32'd0);
    goto_edge(138); check("en_d0", 32'(an), 32'hF);
    goto_edge(154); check("en_d1", 32'(an), 32'hD);
    goto_edge(170); check("en_d2", 32'(an), 32'hF);
    goto_edge(186); check("en_d3", 32'(an), 32'h7);
    goto_edge(190); digit_en = 4'hF;

    // Frame 4 (edge 196): loads mid-frame, last one wins next frame.
    goto_edge(229); do_load(16'hABCD, 4'b0000);
    goto_edge(234); digit("f4d2", 4'hB, 7'h24);
    goto_edge(244); do_load(16'hEEEE, 4'b0000);
    goto_edge(250); digit("f4d3", 4'h7, 7'h79);

    // Frame 5 (edge 260): all E.
    goto_edge(266); digit("f5d0", 4'hE, 7'h06); check("f5d0_dp", 32'(dp), 32'd1);
    goto_edge(282); digit("f5d1", 4'hD, 7'h06);
    goto_edge(298); digit("f5d2", 4'hB, 7'h06);
    goto_edge(299); do_load(16'h5555, 4'b0000);
    goto_edge(314); digit("f5d3", 4'h7, 7'h06);

    // Load landing on the frame-6 transfer clock (edge 324).
    goto_edge(323); do_load(16'h7777, 4'b0000);
    check("same_fs", 32'(frame_start), 32'd1);
    goto_edge(330); digit("f6d0", 4'hE, 7'h12);
    goto_edge(378); digit("f6d3", 4'h7, 7'h12);
    goto_edge(394); digit("f7d0", 4'hE, 7'h78);
    goto_edge(425); digit("f7d2", 4'hB, 7'h78);

    // Asynchronous reset mid-DRIVE of digit 2, no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'd1);
    check("async_fs", 32'(frame_start), 32'd0);

    repeat (2) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    e = 0;
    goto_edge(4);  check("rr_fs", 32'(frame_start), 32'd1);
    goto_edge(5);  digit("rr_d0", 4'hE, 7'h40);
    goto_edge(22); digit("rr_d1", 4'hD, 7'h40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
